// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI message parser.
//   - channel-voice status nibble constants
//   - byte-class thresholds (system common / real-time)
//   - parser state encoding
//   - data_len(): number of data bytes that follow a channel status
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CTRL     = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;

   // Bytes at or above SYS_MIN are system common; at or above RT_MIN real-time.
   localparam logic [7:0] SYS_MIN  = 8'hF0;
   localparam logic [7:0] RT_MIN   = 8'hF8;

   typedef enum logic [1:0] {
      ST_NO_STATUS = 2'd0,
      ST_WAIT_D1   = 2'd1,
      ST_WAIT_D2   = 2'd2
   } parser_state_t;

   // Program change and channel aftertouch carry one data byte; the rest two.
   function automatic logic [1:0] data_len(input logic [3:0] nibble);
      logic [1:0] len;
      case (nibble)
         PROG, CH_AT:                            len = 2'd1;
         NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PITCH: len = 2'd2;
         default:                                len = 2'd2;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: consumes received MIDI bytes, tracks (running) status,
// assembles channel-voice messages and reports Note On / Note Off events.
//   CLK       system clock
//   RESET     asynchronous active-low reset
//   RX_BYTE   received byte, valid while RX_VALID=1
//   RX_VALID  one-cycle byte strobe
//   RX_ERR    framing error on the strobed byte
//   EV_VALID  one-cycle note event strobe (one cycle after the last data byte)
//   EV_ON     1 = note on, 0 = note off (including note on with velocity 0)
//   EV_CH     event channel
//   EV_NOTE   event note number
//   EV_VEL    event velocity
//   LED       {note held, last note-on number}
//   ERR_CNT   saturating count of errored bytes
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter logic       OMNI    = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] RX_BYTE,
   input  logic       RX_VALID,
   input  logic       RX_ERR,
   output logic       EV_VALID,
   output logic       EV_ON,
   output logic [3:0] EV_CH,
   output logic [6:0] EV_NOTE,
   output logic [6:0] EV_VEL,
   output logic [7:0] LED,
   output logic [3:0] ERR_CNT
);

   parser_state_t state_r, next_state_s;
   logic [7:0]    status_r, status_nxt_s;
   logic [6:0]    d1_r, d1_nxt_s;
   logic [3:0]    err_cnt_r, err_nxt_s;
   logic          ev_fire_s, ev_on_s;
   logic          chan_ok_s, is_note_s;

   logic          ev_valid_r, ev_on_r;
   logic [3:0]    ev_ch_r;
   logic [6:0]    ev_note_r, ev_vel_r;
   logic [7:0]    led_r;

   assign chan_ok_s = OMNI || (status_r[3:0] == CHANNEL);
   assign is_note_s = (status_r[7:4] == NOTE_ON) || (status_r[7:4] == NOTE_OFF);

   // Next-state, running-status, data latch and event detection.
   always_comb begin
      next_state_s = state_r;
      status_nxt_s = status_r;
      d1_nxt_s     = d1_r;
      err_nxt_s    = err_cnt_r;
      ev_fire_s    = 1'b0;
      ev_on_s      = 1'b0;
      if (RX_VALID) begin
         if (RX_ERR) begin
            // Errored byte is dropped regardless of its value.
            if (err_cnt_r != 4'd15) begin
               err_nxt_s = err_cnt_r + 4'd1;
            end else begin
               err_nxt_s = err_cnt_r;
            end
            if (state_r == ST_WAIT_D2) begin
               next_state_s = ST_WAIT_D1;
            end else begin
               next_state_s = state_r;
            end
         end else if (RX_BYTE >= RT_MIN) begin
            // Real-time bytes are transparent.
            next_state_s = state_r;
         end else if (RX_BYTE >= SYS_MIN) begin
            status_nxt_s = 8'h00;
            next_state_s = ST_NO_STATUS;
         end else if (RX_BYTE[7]) begin
            status_nxt_s = RX_BYTE;
            next_state_s = ST_WAIT_D1;
         end else begin
            case (state_r)
               ST_WAIT_D1: begin
                  d1_nxt_s = RX_BYTE[6:0];
                  if (data_len(status_r[7:4]) == 2'd2) begin
                     next_state_s = ST_WAIT_D2;
                  end else begin
                     next_state_s = ST_WAIT_D1;
                  end
               end
               ST_WAIT_D2: begin
                  next_state_s = ST_WAIT_D1;
                  ev_fire_s    = is_note_s && chan_ok_s;
                  ev_on_s      = (status_r[7:4] == NOTE_ON) && (RX_BYTE[6:0] != 7'd0);
               end
               default: begin
                  // No status: data (including SysEx payload) is discarded.
                  next_state_s = state_r;
               end
            endcase
         end
      end else begin
         next_state_s = state_r;
      end
   end

   // Parser state, running status, D1 latch and error counter.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r   <= ST_NO_STATUS;
         status_r  <= 8'h00;
         d1_r      <= 7'd0;
         err_cnt_r <= 4'd0;
      end else begin
         state_r   <= next_state_s;
         status_r  <= status_nxt_s;
         d1_r      <= d1_nxt_s;
         err_cnt_r <= err_nxt_s;
      end
   end

   // Event registers: payload holds until the next event.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ev_valid_r <= 1'b0;
         ev_on_r    <= 1'b0;
         ev_ch_r    <= 4'd0;
         ev_note_r  <= 7'd0;
         ev_vel_r   <= 7'd0;
      end else begin
         ev_valid_r <= ev_fire_s;
         if (ev_fire_s) begin
            ev_on_r   <= ev_on_s;
            ev_ch_r   <= status_r[3:0];
            ev_note_r <= d1_r;
            ev_vel_r  <= RX_BYTE[6:0];
         end else begin
            ev_on_r   <= ev_on_r;
            ev_ch_r   <= ev_ch_r;
            ev_note_r <= ev_note_r;
            ev_vel_r  <= ev_vel_r;
         end
      end
   end

   // LED: note on lights the note; matching note off clears only the held flag.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         led_r <= 8'h00;
      end else if (ev_fire_s) begin
         if (ev_on_s) begin
            led_r <= {1'b1, d1_r};
         end else if (led_r[7] && (led_r[6:0] == d1_r)) begin
            led_r[7] <= 1'b0;
         end else begin
            led_r <= led_r;
         end
      end else begin
         led_r <= led_r;
      end
   end

   assign EV_VALID = ev_valid_r;
   assign EV_ON    = ev_on_r;
   assign EV_CH    = ev_ch_r;
   assign EV_NOTE  = ev_note_r;
   assign EV_VEL   = ev_vel_r;
   assign LED      = led_r;
   assign ERR_CNT  = err_cnt_r;

endmodule
